// File: rtl/glitch_sequencer_if.sv
// Command/status bundle between the UART command handler (master) and the glitch sequencer (slave).
// Optional GLITCH_AUTO_REARM_EN adds repeat_i and attempt_o.
interface glitch_sequencer_if #(
    parameter int TIMEOUT_W = 24
);
    logic                 arm_i;
    logic                 abort_i;
    logic [1:0]           trig_mode_i;
    logic [15:0]          reset_cycles_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic                 armed_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 timeout_o;
    logic [2:0]           state_o;
`ifdef GLITCH_AUTO_REARM_EN
    logic [7:0]           repeat_i;
    logic [7:0]           attempt_o;

    modport master (
        output arm_i, abort_i, trig_mode_i, reset_cycles_i, timeout_i, repeat_i,
        input  armed_o, busy_o, done_o, timeout_o, state_o, attempt_o
    );
    modport slave (
        input  arm_i, abort_i, trig_mode_i, reset_cycles_i, timeout_i, repeat_i,
        output armed_o, busy_o, done_o, timeout_o, state_o, attempt_o
    );
`else
    modport master (
        output arm_i, abort_i, trig_mode_i, reset_cycles_i, timeout_i,
        input  armed_o, busy_o, done_o, timeout_o, state_o
    );
    modport slave (
        input  arm_i, abort_i, trig_mode_i, reset_cycles_i, timeout_i,
        output armed_o, busy_o, done_o, timeout_o, state_o
    );
`endif
endinterface

// File: rtl/glitch_sequencer.sv
// Glitch attempt sequencer: target reset, trigger wait, pulser start and completion tracking.
// Optional macro GLITCH_AUTO_REARM_EN repeats the attempt repeat_i times per arm.
module glitch_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    glitch_sequencer_if.slave  cmd,
    input  logic               trigger_i,
    input  logic               pulser_busy_i,
    output logic               pulser_en_o,
    output logic               target_reset_o
);
    localparam int CNT_W = (TIMEOUT_W > 16) ? TIMEOUT_W : 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRESET = 3'd1,
        ST_ARMED  = 3'd2,
        ST_FIRE   = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             mode_q;
    logic [15:0]            rcyc_q;
    logic [TIMEOUT_W-1:0]   tout_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_d_q, rise_q, fall_q, level_q;
    logic                   pulser_en_q, target_reset_q, armed_q, busy_q, done_q, timeout_q;
    logic                   latch_s, done_s, tmo_s, cond_s, edge_ok_s, trig_s;
`ifdef GLITCH_AUTO_REARM_EN
    logic [7:0]             rep_q, attempt_q, attempt_d, next_att_s, rep_eff_s;

    assign next_att_s = attempt_q + 8'd1;
    assign rep_eff_s  = (rep_q == 8'd0) ? 8'd1 : rep_q;
`endif

    assign trig_s    = sync_q[SYNC_STAGES-1];
    // An edge flag in the first ARMED cycle came from before entry, so it must not fire.
    assign edge_ok_s = (cnt_q != '0);

    // Trigger condition select for the latched mode.
    always_comb begin
        cond_s = 1'b0;
        case (mode_q)
            2'b00:   cond_s = 1'b1;
            2'b01:   cond_s = rise_q & edge_ok_s;
            2'b10:   cond_s = fall_q & edge_ok_s;
            2'b11:   cond_s = level_q;
            default: cond_s = 1'b0;
        endcase
    end

    // Next-state, phase counter and completion strobes.
    always_comb begin
        state_d = state_q;
        latch_s = 1'b0;
        done_s  = 1'b0;
        tmo_s   = 1'b0;
`ifdef GLITCH_AUTO_REARM_EN
        attempt_d = attempt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd.arm_i && !cmd.abort_i) begin
                    latch_s = 1'b1;
                    state_d = (cmd.reset_cycles_i != 16'd0) ? ST_TRESET : ST_ARMED;
`ifdef GLITCH_AUTO_REARM_EN
                    attempt_d = 8'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRESET: begin
                if (cnt_q == (CNT_W'(rcyc_q) - CNT_W'(1))) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_TRESET;
                end
            end
            ST_ARMED: begin
                if (cond_s) begin
                    state_d = ST_FIRE;
                end else if ((tout_q != '0) && (cnt_q == (CNT_W'(tout_q) - CNT_W'(1)))) begin
                    state_d = ST_IDLE;
                    tmo_s   = 1'b1;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_FIRE: state_d = ST_RUN;
            ST_RUN: begin
                if ((cnt_q != '0) && !pulser_busy_i) begin
`ifdef GLITCH_AUTO_REARM_EN
                    attempt_d = next_att_s;
                    if (next_att_s < rep_eff_s) begin
                        state_d = (rcyc_q != 16'd0) ? ST_TRESET : ST_ARMED;
                    end else begin
                        state_d = ST_IDLE;
                        done_s  = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    done_s  = 1'b1;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cmd.abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_s  = 1'b0;
            tmo_s   = 1'b0;
`ifdef GLITCH_AUTO_REARM_EN
            attempt_d = attempt_q;
`endif
        end else begin
            state_d = state_d;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, counters, config latches, trigger conditioning and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            mode_q         <= 2'b00;
            rcyc_q         <= 16'd0;
            tout_q         <= '0;
            sync_q         <= '0;
            trig_d_q       <= 1'b0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            level_q        <= 1'b0;
            pulser_en_q    <= 1'b0;
            target_reset_q <= 1'b0;
            armed_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef GLITCH_AUTO_REARM_EN
            rep_q          <= 8'd0;
            attempt_q      <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], trigger_i};
            trig_d_q <= trig_s;
            rise_q   <= trig_s & ~trig_d_q;
            fall_q   <= ~trig_s & trig_d_q;
            level_q  <= trig_s;
            if (latch_s) begin
                mode_q <= cmd.trig_mode_i;
                rcyc_q <= cmd.reset_cycles_i;
                tout_q <= cmd.timeout_i;
`ifdef GLITCH_AUTO_REARM_EN
                rep_q  <= cmd.repeat_i;
`endif
            end
            pulser_en_q    <= (state_d == ST_FIRE);
            target_reset_q <= (state_d == ST_TRESET);
            armed_q        <= (state_d == ST_ARMED);
            busy_q         <= (state_d != ST_IDLE);
            done_q         <= done_s;
            timeout_q      <= tmo_s;
`ifdef GLITCH_AUTO_REARM_EN
            attempt_q      <= attempt_d;
`endif
        end
    end

    assign pulser_en_o    = pulser_en_q;
    assign target_reset_o = target_reset_q;
    assign cmd.armed_o    = armed_q;
    assign cmd.busy_o     = busy_q;
    assign cmd.done_o     = done_q;
    assign cmd.timeout_o  = timeout_q;
    assign cmd.state_o    = state_q;
`ifdef GLITCH_AUTO_REARM_EN
    assign cmd.attempt_o  = attempt_q;
`endif
endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomized bench for glitch_sequencer: each attempt is predicted as a timeline of phases
// and every cycle's outputs are compared against it.
module tb_glitch_sequencer;
    localparam int S    = 2;
    localparam int TW   = 24;
    localparam int D    = S + 1;
    localparam int MAXC = 1400;

    logic clk = 1'b0;
    logic rst;
    logic trigger_i;
    logic pulser_busy_i;
    logic pulser_en_o;
    logic target_reset_o;

    always #5 clk = ~clk;

    glitch_sequencer_if #(.TIMEOUT_W(TW)) cmd ();

    glitch_sequencer #(.SYNC_STAGES(S), .TIMEOUT_W(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd),
        .trigger_i      (trigger_i),
        .pulser_busy_i  (pulser_busy_i),
        .pulser_en_o    (pulser_en_o),
        .target_reset_o (target_reset_o)
    );

    int checks   = 0;
    int failures = 0;

    int st   [MAXC];
    bit dn   [MAXC];
    bit tm   [MAXC];
    int ainc [MAXC];
    bit wave [MAXC];
    int fire_q[$];
    int exp_attempt = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit w(input int i);
        return wave[(i < 0) ? 0 : i];
    endfunction

    // Trigger condition as seen by the sequencer in cycle c, for an ARMED phase entered at a.
    function automatic bit fires(input int mode, input int c, input int a);
        case (mode)
            0:       return (c == a);
            1:       return (c > a) && w(c - D) && !w(c - D - 1);
            2:       return (c > a) && !w(c - D) && w(c - D - 1);
            default: return w(c - D);
        endcase
    endfunction

    task automatic run_attempt(input int mode, input int rc, input int to, input int rep,
                               input bit init, input int tg1, input int tg2, input int blen,
                               input int abc_in, input bit arm_abort);
        int abc, s, a, c, f, x, endc, rep_eff, res, cur, pick;
        bit ended, pb;
        abc = abc_in;
        for (int i = 0; i < MAXC; i++) begin
            st[i] = 0; dn[i] = 1'b0; tm[i] = 1'b0; ainc[i] = 0;
            wave[i] = init ^ (i >= tg1) ^ (i >= tg2);
        end
        fire_q.delete();
`ifdef GLITCH_AUTO_REARM_EN
        rep_eff = (rep == 0) ? 1 : rep;
`else
        rep_eff = 1;
`endif
        endc = 3;
        if (arm_abort) begin
            abc = 0;
        end else begin
            s = 1;
            ended = 1'b0;
            for (int k = 0; k < rep_eff && !ended; k++) begin
                for (int i = 0; i < rc; i++) st[s + i] = 1;
                a = s + rc;
                c = a;
                res = 0;
                while (res == 0) begin
                    st[c] = 2;
                    if (fires(mode, c, a)) res = 1;
                    else if (to != 0 && c - a == to - 1) res = 2;
                    else if (c - a >= 150) res = 3;
                    else c++;
                end
                if (res == 1) begin
                    f = c + 1;
                    st[f] = 3;
                    fire_q.push_back(f);
                    x = (f + blen + 1 > f + 2) ? f + blen + 1 : f + 2;
                    for (int i = f + 1; i <= x; i++) st[i] = 4;
                    ainc[x + 1] = 1;
                    if (k == rep_eff - 1) begin
                        dn[x + 1] = 1'b1;
                        endc = x + 1;
                        ended = 1'b1;
                    end else begin
                        s = x + 1;
                    end
                end else if (res == 2) begin
                    tm[c + 1] = 1'b1;
                    endc = c + 1;
                    ended = 1'b1;
                end else begin
                    pick = $urandom_range(a, c);
                    if (abc < 0 || abc > pick) abc = pick;
                    endc = c;
                    ended = 1'b1;
                end
            end
            if (abc >= 1 && st[abc] != 0) begin
                for (int i = abc + 1; i < MAXC; i++) begin
                    st[i] = 0; dn[i] = 1'b0; tm[i] = 1'b0; ainc[i] = 0;
                end
                endc = abc + 1;
            end
        end

        repeat (D + 2) begin
            @(posedge clk); #1;
            trigger_i = wave[0]; cmd.arm_i = 1'b0; cmd.abort_i = 1'b0; pulser_busy_i = 1'b0;
        end
        cur = exp_attempt;
        for (int c2 = 0; c2 <= endc + 2; c2++) begin
            @(posedge clk); #1;
            if (c2 == 0) begin
                cmd.arm_i          = 1'b1;
                cmd.trig_mode_i    = 2'(mode);
                cmd.reset_cycles_i = 16'(rc);
                cmd.timeout_i      = TW'(to);
`ifdef GLITCH_AUTO_REARM_EN
                cmd.repeat_i       = 8'(rep);
`endif
            end else begin
                cmd.arm_i          = (st[c2] != 0) && ($urandom_range(0, 3) == 0);
                cmd.trig_mode_i    = 2'($urandom);
                cmd.reset_cycles_i = 16'($urandom);
                cmd.timeout_i      = TW'($urandom);
`ifdef GLITCH_AUTO_REARM_EN
                cmd.repeat_i       = 8'($urandom);
`endif
            end
            cmd.abort_i = (c2 == abc);
            trigger_i   = wave[c2];
            pb = 1'b0;
            foreach (fire_q[j]) if (c2 >= fire_q[j] + 1 && c2 <= fire_q[j] + blen) pb = 1'b1;
            pulser_busy_i = pb;
            if (c2 == 1 && !arm_abort) cur = 0;
            cur += ainc[c2];
            @(negedge clk);
            check_eq($sformatf("state c%0d", c2), 32'(cmd.state_o), 32'(st[c2]));
            check_eq($sformatf("outs c%0d", c2),
                     {26'd0, pulser_en_o, target_reset_o, cmd.armed_o, cmd.busy_o, cmd.done_o, cmd.timeout_o},
                     {26'd0, st[c2] == 3, st[c2] == 1, st[c2] == 2, st[c2] != 0, dn[c2], tm[c2]});
`ifdef GLITCH_AUTO_REARM_EN
            check_eq($sformatf("attempt c%0d", c2), 32'(cmd.attempt_o), 32'(cur));
`endif
        end
        exp_attempt = cur;
    endtask

    initial begin
        rst = 1'b1;
        trigger_i = 1'b0; pulser_busy_i = 1'b0;
        cmd.arm_i = 1'b0; cmd.abort_i = 1'b0; cmd.trig_mode_i = 2'b00;
        cmd.reset_cycles_i = 16'd0; cmd.timeout_i = '0;
`ifdef GLITCH_AUTO_REARM_EN
        cmd.repeat_i = 8'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset state", 32'(cmd.state_o), 32'd0);
        check_eq("reset outs",
                 {26'd0, pulser_en_o, target_reset_o, cmd.armed_o, cmd.busy_o, cmd.done_o, cmd.timeout_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_attempt(1, 5, 0, 1, 1'b0, 20, MAXC, 6, -1, 1'b0);
        run_attempt(0, 0, 0, 1, 1'b1, MAXC, MAXC, 4, -1, 1'b0);
        run_attempt(2, 0, 100, 1, 1'b0, MAXC, MAXC, 3, -1, 1'b0);
        run_attempt(1, 1000, 0, 1, 1'b0, 30, MAXC, 3, 10, 1'b0);
        run_attempt(0, 3, 0, 1, 1'b0, MAXC, MAXC, 2, -1, 1'b0);
        run_attempt(1, 3, 30, 1, 1'b1, MAXC, MAXC, 2, -1, 1'b0);
        run_attempt(3, 3, 30, 1, 1'b1, MAXC, MAXC, 2, -1, 1'b0);
        run_attempt(0, 0, 0, 1, 1'b0, MAXC, MAXC, 2, -1, 1'b1);
        run_attempt(2, 0, 1, 1, 1'b1, 1, MAXC, 2, -1, 1'b0);
`ifdef GLITCH_AUTO_REARM_EN
        run_attempt(0, 0, 0, 3, 1'b0, MAXC, MAXC, 10, -1, 1'b0);
        run_attempt(0, 2, 0, 3, 1'b0, MAXC, MAXC, 4, 40, 1'b0);
`endif
        for (int n = 0; n < 40; n++) begin
            int m, rc, to, tg1;
            m   = $urandom_range(0, 3);
            rc  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
            to  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            tg1 = $urandom_range(1, 60);
            run_attempt(m, rc, to, $urandom_range(0, 2), 1'($urandom_range(0, 1)), tg1,
                        tg1 + $urandom_range(1, 30), $urandom_range(0, 10),
                        ($urandom_range(0, 4) == 0) ? $urandom_range(1, 60) : -1,
                        $urandom_range(0, 14) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Sequences one glitch attempt around the pulser: optionally resets the target, waits for the selected trigger condition, then starts the pulser and tracks it until it finishes.
- Sits between the UART command handler (arm/abort/config) and the pulser (start/busy).
- Drives the target-reset and pulser-enable outputs of the glitch controller top level.
- Consumes the external trigger input.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for trigger_i (minimum 2).
- TIMEOUT_W, 24, width of the trigger-wait timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- arm_i  in  1  one-cycle request to start an attempt.
- abort_i  in  1  one-cycle request to cancel the current attempt.
- trig_mode_i  in  2  trigger condition: 00 immediate, 01 rising edge, 10 falling edge, 11 high level.
- reset_cycles_i  in  16  number of cycles to assert target reset; 0 skips the reset phase.
- timeout_i  in  TIMEOUT_W  maximum cycles to wait for the trigger; 0 waits forever.
- trigger_i  in  1  asynchronous trigger from the target.
- pulser_busy_i  in  1  pulser busy flag.
- pulser_en_o  out  1  one-cycle start strobe to the pulser.
- target_reset_o  out  1  target reset, active-high.
- armed_o  out  1  high while waiting for the trigger.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle strobe when an attempt completes normally.
- timeout_o  out  1  one-cycle strobe when the trigger wait expires.
- state_o  out  3  current state encoding.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high. On reset, every output is 0, state is IDLE, and all counters and synchroniser flops are 0.
- Trigger conditioning:
  - trigger_i passes through SYNC_STAGES flops to produce trig_s, plus one history flop trig_d.
  - Rising edge = trig_s & ~trig_d. Falling edge = ~trig_s & trig_d. Level = trig_s.
- States and state_o encoding: IDLE=0, TRESET=1, ARMED=2, FIRE=3, RUN=4.
- IDLE:
  - On arm_i, latch trig_mode_i, reset_cycles_i and timeout_i.
  - Go to TRESET if the latched reset_cycles is nonzero, else to ARMED.
  - Config inputs are sampled only at this moment; changes afterwards have no effect on the attempt.
- TRESET:
  - target_reset_o=1 for exactly reset_cycles clock cycles, then go to ARMED.
  - target_reset_o is registered and deasserts in the first ARMED cycle.
- ARMED:
  - armed_o=1.
  - Mode 00 goes to FIRE on the first ARMED cycle.
  - Other modes go to FIRE on the cycle the selected condition is true.
  - Timeout counter starts at 0 on ARMED entry and increments each cycle. If timeout is nonzero and the counter reaches timeout-1 without a trigger, pulse timeout_o for one cycle and go to IDLE.
  - If the trigger and the final timeout cycle coincide, the trigger wins.
  - Edges present before ARMED entry are ignored: trig_d tracks continuously, so only an edge arriving while ARMED fires.
  - A level already high at entry fires immediately.
- FIRE: pulser_en_o=1 for exactly this one cycle, then go to RUN.
- RUN:
  - Stay at least 2 cycles (grace for the pulser to assert busy).
  - After that, exit on the first cycle with pulser_busy_i=0. Pulse done_o for one cycle and go to IDLE.
- Latency: a rising edge on trigger_i stable before a clk edge produces pulser_en_o high SYNC_STAGES+2 cycles later (sync, edge-detect register, FIRE).
- arm_i while not IDLE: ignored.
- abort_i in any non-IDLE state:
  - Next state is IDLE; target_reset_o clears and pulser_en_o stays 0 on the next cycle.
  - No done_o and no timeout_o.
  - The pulser itself is not stopped.
- abort_i and arm_i in the same cycle: abort wins. From IDLE this means arm is ignored.
- done_o and timeout_o are mutually exclusive and never assert in the same cycle as abort.
- Counters are saturating-safe: a counter compare match always ends the state, so no wrap-around occurs.

Optional Feature:
- Macro: GLITCH_AUTO_REARM_EN.
- When defined:
  - Adds input repeat_i[7:0], latched at arm time, and output attempt_o[7:0].
  - After RUN completes, if the completed-attempt count is less than repeat, return to TRESET (or ARMED when reset_cycles=0) without a new arm_i.
  - done_o pulses only after the final attempt.
  - attempt_o counts completed attempts and resets to 0 on arm.
  - repeat=0 behaves as repeat=1.
  - A timeout or abort ends the whole sequence.
- When undefined: single attempt per arm, no extra ports.

Test Plan:
- Arm, reset_cycles=5, mode 01, timeout=0; trigger_i rises 20 cycles later → target_reset_o high exactly 5 cycles; pulser_en_o one cycle, SYNC_STAGES+2 after the edge; done_o one cycle after busy falls.
- Mode 00, reset_cycles=0 → pulser_en_o high on the 2nd cycle after arm_i (IDLE→ARMED→FIRE); target_reset_o never asserts.
- Mode 10, timeout=100, trigger held low → timeout_o pulses once, 100 cycles after ARMED entry; pulser_en_o never asserts; state_o returns to 0.
- abort_i during TRESET with reset_cycles=1000 → target_reset_o low the next cycle, busy_o=0, no done_o or timeout_o; a following arm_i starts a fresh attempt.
- trigger_i already high and mode 01 at arm, then stays high → no fire. With mode 11 under the same conditions → fires on the first ARMED cycle.
- With GLITCH_AUTO_REARM_EN, repeat=3, mode 00, pulser busy 10 cycles → pulser_en_o asserts 3 times, attempt_o ends at 3, single done_o after the third.
